// File: rtl/mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// mem_stage_pipe : registered MEM stage, req/ack memory port, valid/ready WB
// Revision       : 1.0
// ============================================================================
module mem_stage_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 20,
    parameter int REG_W     = 7,
    parameter int OP_W      = 5,
    parameter int MEM_WORDS = 1048576,
    parameter int OUT_SEL   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [REG_W-1:0]  in_rd_alu,
    input  logic [REG_W-1:0]  in_rd_mem,
    input  logic [REG_W-1:0]  in_branch,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_bank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [OP_W-1:0]   wb_opcode,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_wr_en,
    output logic [REG_W-1:0]  wb_branch,
    output logic              addr_err
);

    localparam logic [OP_W-1:0] c_op_lv  = OP_W'(1);
    localparam logic [OP_W-1:0] c_op_add = OP_W'(2);
    localparam logic [OP_W-1:0] c_op_sub = OP_W'(3);
    localparam logic [OP_W-1:0] c_op_mul = OP_W'(4);
    localparam logic [OP_W-1:0] c_op_div = OP_W'(5);
    localparam logic [OP_W-1:0] c_op_cp  = OP_W'(6);
    localparam logic [OP_W-1:0] c_op_slr = OP_W'(9);
    localparam logic [OP_W-1:0] c_op_gp  = OP_W'(10);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                wb_valid_q;
    logic [OP_W-1:0]     wb_opcode_q;
    logic [REG_W-1:0]    wb_rd_q;
    logic [DATA_W-1:0]   wb_result_q;
    logic                wb_wr_en_q;
    logic [REG_W-1:0]    wb_branch_q;
    logic                addr_err_q;
    logic [OP_W-1:0]     pend_op_q;
    logic [REG_W-1:0]    pend_rd_q;
    logic [REG_W-1:0]    pend_branch_q;
    logic [DATA_W-1:0]   skid_result_q;
    logic [REG_W-1:0]    skid_rd_q;
    logic                skid_wr_en_q;

    logic                wb_free;
    logic                accept;
    logic                is_cp;
    logic                is_gp;
    logic                is_mem_op;
    logic                addr_oor;
    logic                alu_wr_en;
    logic                mem_done_wr_en;
    logic [DATA_W-1:0]   mem_done_result;
    logic [REG_W-1:0]    mem_done_rd;
    logic                wb_load;
    logic [OP_W-1:0]     wb_opcode_d;
    logic [REG_W-1:0]    wb_rd_d;
    logic [DATA_W-1:0]   wb_result_d;
    logic                wb_wr_en_d;
    logic [REG_W-1:0]    wb_branch_d;

    // The WB register can take a new result if empty or being drained this cycle.
    assign wb_free   = !wb_valid_q || wb_ready;
    assign in_ready  = rst_n && (state_q == S_IDLE) && wb_free;
    assign accept    = in_valid && in_ready;
    assign is_cp     = (in_opcode == c_op_cp);
    assign is_gp     = (in_opcode == c_op_gp);
    assign is_mem_op = is_cp || is_gp;
    assign addr_oor  = (64'(in_addr) >= 64'(MEM_WORDS));

    assign mem_done_wr_en  = (state_q == S_LOAD);
    assign mem_done_result = mem_done_wr_en ? mem_rdata : '0;
    assign mem_done_rd     = mem_done_wr_en ? pend_rd_q : '0;

    always_comb begin
        alu_wr_en = 1'b0;
        case (in_opcode)
            c_op_lv, c_op_add, c_op_sub, c_op_mul, c_op_div, c_op_slr: alu_wr_en = 1'b1;
            default: alu_wr_en = 1'b0;
        endcase
    end

    always_comb begin
        wb_load     = 1'b0;
        wb_opcode_d = wb_opcode_q;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        wb_wr_en_d  = wb_wr_en_q;
        wb_branch_d = wb_branch_q;
        case (state_q)
            S_IDLE: begin
                // Everything except an in-range CP/GP completes in one cycle.
                if (accept && !(is_mem_op && !addr_oor)) begin
                    wb_load     = 1'b1;
                    wb_opcode_d = in_opcode;
                    wb_branch_d = in_branch;
                    if (is_mem_op) begin
                        wb_rd_d     = '0;
                        wb_result_d = '0;
                        wb_wr_en_d  = 1'b0;
                    end else begin
                        wb_rd_d     = in_rd_alu;
                        wb_result_d = in_alu_result;
                        wb_wr_en_d  = alu_wr_en;
                    end
                end
            end
            S_LOAD, S_STORE: begin
                if (mem_ack && wb_free) begin
                    wb_load     = 1'b1;
                    wb_opcode_d = pend_op_q;
                    wb_branch_d = pend_branch_q;
                    wb_rd_d     = mem_done_rd;
                    wb_result_d = mem_done_result;
                    wb_wr_en_d  = mem_done_wr_en;
                end
            end
            S_HOLD: begin
                if (wb_free) begin
                    wb_load     = 1'b1;
                    wb_opcode_d = pend_op_q;
                    wb_branch_d = pend_branch_q;
                    wb_rd_d     = skid_rd_q;
                    wb_result_d = skid_result_q;
                    wb_wr_en_d  = skid_wr_en_q;
                end
            end
            default: wb_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_opcode_q   <= '0;
            wb_rd_q       <= '0;
            wb_result_q   <= '0;
            wb_wr_en_q    <= 1'b0;
            wb_branch_q   <= '0;
            addr_err_q    <= 1'b0;
            pend_op_q     <= '0;
            pend_rd_q     <= '0;
            pend_branch_q <= '0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_wr_en_q  <= 1'b0;
        end else begin
            if (wb_load) begin
                wb_valid_q  <= 1'b1;
                wb_opcode_q <= wb_opcode_d;
                wb_rd_q     <= wb_rd_d;
                wb_result_q <= wb_result_d;
                wb_wr_en_q  <= wb_wr_en_d;
                wb_branch_q <= wb_branch_d;
            end else if (wb_ready) begin
                wb_valid_q  <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept && is_mem_op) begin
                        if (addr_oor) begin
                            addr_err_q <= 1'b1;
                        end else begin
                            mem_req_q     <= 1'b1;
                            mem_we_q      <= is_gp;
                            mem_addr_q    <= in_addr[ADDR_W-1:0];
                            if (is_gp) begin
                                mem_wdata_q <= in_store_data;
                            end
                            pend_op_q     <= in_opcode;
                            pend_rd_q     <= in_rd_mem;
                            pend_branch_q <= in_branch;
                            state_q       <= is_gp ? S_STORE : S_LOAD;
                        end
                    end
                end
                S_LOAD, S_STORE: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (wb_free) begin
                            state_q <= S_IDLE;
                        end else begin
                            skid_result_q <= mem_done_result;
                            skid_rd_q     <= mem_done_rd;
                            skid_wr_en_q  <= mem_done_wr_en;
                            state_q       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (wb_free) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_bank  = 2'(OUT_SEL);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_opcode = wb_opcode_q;
    assign wb_rd     = wb_rd_q;
    assign wb_result = wb_result_q;
    assign wb_wr_en  = wb_wr_en_q;
    assign wb_branch = wb_branch_q;
    assign addr_err  = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_pipe : directed table, corner sequences and randomized run
// Revision          : 1.0
// ============================================================================
module tb_mem_stage_pipe;

    localparam int DW = 32;
    localparam int AW = 20;
    localparam int RW = 7;
    localparam int OW = 5;
    localparam int MW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] in_opcode = '0;
    logic [RW-1:0] in_rd_alu = '0;
    logic [RW-1:0] in_rd_mem = '0;
    logic [RW-1:0] in_branch = '0;
    logic [DW-1:0] in_alu_result = '0;
    logic [DW-1:0] in_addr = '0;
    logic [DW-1:0] in_store_data = '0;
    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_bank;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [OW-1:0] wb_opcode;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_result;
    logic          wb_wr_en;
    logic [RW-1:0] wb_branch;
    logic          addr_err;

    always #5 clk = ~clk;

    mem_stage_pipe #(
        .DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .OP_W(OW), .MEM_WORDS(MW), .OUT_SEL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd_alu(in_rd_alu), .in_rd_mem(in_rd_mem),
        .in_branch(in_branch), .in_alu_result(in_alu_result), .in_addr(in_addr),
        .in_store_data(in_store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_opcode(wb_opcode), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_wr_en(wb_wr_en), .wb_branch(wb_branch),
        .addr_err(addr_err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic writes_reg(input logic [OW-1:0] op);
        return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9};
    endfunction

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
        logic [RW-1:0] br;
        logic          exp_wr;
    } pt_vec_t;

    typedef struct {
        logic [OW-1:0] op;
        logic [RW-1:0] rd;
        logic          rd_chk;
        logic [DW-1:0] res;
        logic          wr;
        logic [RW-1:0] br;
    } wb_exp_t;

    pt_vec_t       vecs[10];
    wb_exp_t       q[$];
    logic [DW-1:0] mem_model[0:255];
    logic          pend;
    logic          p_we;
    logic [DW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          exp_err;
    logic          acc_seen;
    int            wait_cnt;
    int            n_hs;

    // Transaction-level reference: every accepted instruction yields exactly one WB entry, in order.
    task automatic monitor();
        wb_exp_t e;
        acc_seen = in_valid && in_ready;
        chk("addr_err", addr_err, exp_err);
        chk("spurious_wb", {31'b0, wb_valid && (q.size() == 0)}, 0);
        if (wb_valid && wb_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("rnd_wb_opcode", wb_opcode, e.op);
            chk("rnd_wb_result", wb_result, e.res);
            chk("rnd_wb_wr_en", wb_wr_en, e.wr);
            chk("rnd_wb_branch", wb_branch, e.br);
            if (e.rd_chk) chk("rnd_wb_rd", wb_rd, e.rd);
        end
        chk("spurious_req", {31'b0, mem_req && !pend}, 0);
        chk("accept_while_busy", {31'b0, acc_seen && pend}, 0);
        if (mem_req && pend) begin
            chk("rnd_mem_we", mem_we, p_we);
            chk("rnd_mem_addr", mem_addr, p_addr);
            if (p_we) chk("rnd_mem_wdata", mem_wdata, p_wdata);
            if (mem_ack) pend = 1'b0;
        end
        if (acc_seen) begin
            e.op = in_opcode;
            e.br = in_branch;
            e.rd_chk = 1'b1;
            if (in_opcode == 5'd6 || in_opcode == 5'd10) begin
                if (in_addr >= MW) begin
                    exp_err = 1'b1;
                    e.rd = '0; e.rd_chk = 1'b0; e.res = '0; e.wr = 1'b0;
                end else begin
                    pend = 1'b1;
                    p_we = (in_opcode == 5'd10);
                    p_addr = in_addr;
                    p_wdata = in_store_data;
                    if (p_we) begin
                        mem_model[in_addr[7:0]] = in_store_data;
                        e.rd = '0; e.res = '0; e.wr = 1'b0;
                    end else begin
                        e.rd = in_rd_mem; e.res = mem_model[in_addr[7:0]]; e.wr = 1'b1;
                    end
                end
            end else begin
                e.rd = in_rd_alu; e.res = in_alu_result; e.wr = writes_reg(in_opcode);
            end
            q.push_back(e);
        end
    endtask

    task automatic new_instr();
        int r;
        r = $urandom_range(0, 9);
        in_opcode = (r < 2) ? 5'd6 : (r < 4) ? 5'd10 : 5'($urandom_range(0, 31));
        if ($urandom_range(0, 15) == 0)
            in_addr = $urandom_range(0, 1) ? 32'(256 + $urandom_range(0, 50)) : $urandom;
        else
            in_addr = 32'($urandom_range(0, 255));
        in_rd_alu = 7'($urandom);
        in_rd_mem = 7'($urandom);
        in_branch = 7'($urandom);
        in_alu_result = $urandom;
        in_store_data = $urandom;
    endtask

    task automatic drive(input logic drain);
        if (drain) begin
            in_valid = 1'b0;
            wb_ready = 1'b1;
        end else begin
            if (acc_seen || !in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    new_instr();
                end else begin
                    in_valid = 1'b0;
                end
            end
            wb_ready = ($urandom_range(0, 2) != 0);
        end
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                mem_rdata = mem_model[mem_addr[7:0]];
                wait_cnt = $urandom_range(0, 3);
            end else begin
                wait_cnt--;
            end
        end else if (!drain && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        vecs[0] = '{5'd2,  32'h0000_00AA, 7'd5,  7'h01, 1'b1};
        vecs[1] = '{5'd3,  32'h1111_0003, 7'd6,  7'h02, 1'b1};
        vecs[2] = '{5'd4,  32'h2222_0004, 7'd7,  7'h03, 1'b1};
        vecs[3] = '{5'd5,  32'h3333_0005, 7'd8,  7'h04, 1'b1};
        vecs[4] = '{5'd9,  32'h4444_0009, 7'd9,  7'h05, 1'b1};
        vecs[5] = '{5'd1,  32'h5555_0001, 7'd10, 7'h06, 1'b1};
        vecs[6] = '{5'd0,  32'h6666_0000, 7'd11, 7'h07, 1'b0};
        vecs[7] = '{5'd7,  32'h7777_0007, 7'd12, 7'h08, 1'b0};
        vecs[8] = '{5'd31, 32'h8888_001F, 7'd13, 7'h09, 1'b0};
        vecs[9] = '{5'd8,  32'hFFFF_FFFF, 7'd127, 7'h7F, 1'b0};
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;

        // Reset state
        #12;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_addr_err", addr_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back pass-through table
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_opcode = vecs[i].op;
            in_alu_result = vecs[i].alu;
            in_rd_alu = vecs[i].rd;
            in_rd_mem = 7'd99;
            in_branch = vecs[i].br;
            #1;
            chk("pt_in_ready", in_ready, 1);
            tick();
            chk("pt_wb_valid", wb_valid, 1);
            chk("pt_wb_result", wb_result, vecs[i].alu);
            chk("pt_wb_rd", wb_rd, vecs[i].rd);
            chk("pt_wb_wr_en", wb_wr_en, vecs[i].exp_wr);
            chk("pt_wb_opcode", wb_opcode, vecs[i].op);
            chk("pt_wb_branch", wb_branch, vecs[i].br);
        end
        in_valid = 1'b0;
        tick();
        chk("pt_wb_drained", wb_valid, 0);

        // CP with ack in the third request cycle
        in_valid = 1'b1; in_opcode = 5'd6; in_addr = 32'h10; in_rd_mem = 7'd12;
        in_rd_alu = 7'd3; in_branch = 7'h11;
        tick();
        in_valid = 1'b0;
        chk("cp_req_c1", mem_req, 1);
        chk("cp_we", mem_we, 0);
        chk("cp_addr", mem_addr, 32'h10);
        chk("cp_in_ready", in_ready, 0);
        chk("cp_wb_idle", wb_valid, 0);
        tick();
        chk("cp_req_c2", mem_req, 1);
        chk("cp_addr_c2", mem_addr, 32'h10);
        tick();
        chk("cp_req_c3", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("cp_req_drop", mem_req, 0);
        chk("cp_wb_valid", wb_valid, 1);
        chk("cp_wb_rd", wb_rd, 12);
        chk("cp_wb_result", wb_result, 32'hDEAD_BEEF);
        chk("cp_wb_wr_en", wb_wr_en, 1);
        chk("cp_wb_opcode", wb_opcode, 6);
        chk("cp_wb_branch", wb_branch, 7'h11);
        tick();
        chk("cp_wb_consumed", wb_valid, 0);

        // GP store
        in_valid = 1'b1; in_opcode = 5'd10; in_addr = 32'h20; in_store_data = 32'h1234;
        in_branch = 7'h22;
        tick();
        in_valid = 1'b0;
        chk("gp_req", mem_req, 1);
        chk("gp_we", mem_we, 1);
        chk("gp_wdata", mem_wdata, 32'h1234);
        chk("gp_addr", mem_addr, 32'h20);
        chk("gp_bank", mem_bank, 2);
        tick();
        chk("gp_req_held", mem_req, 1);
        chk("gp_wdata_held", mem_wdata, 32'h1234);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("gp_req_drop", mem_req, 0);
        chk("gp_wb_valid", wb_valid, 1);
        chk("gp_wb_wr_en", wb_wr_en, 0);
        chk("gp_wb_rd", wb_rd, 0);
        chk("gp_wb_result", wb_result, 0);
        chk("gp_wb_opcode", wb_opcode, 10);
        tick();

        // Backpressure at load completion, result delivered exactly once
        in_valid = 1'b1; in_opcode = 5'd6; in_addr = 32'h30; in_rd_mem = 7'd9;
        tick();
        in_valid = 1'b0;
        wb_ready = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'd7;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wb_valid", wb_valid, 1);
            chk("bp_wb_result", wb_result, 7);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        wb_ready = 1'b1;
        n_hs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_valid && wb_ready) n_hs++;
        end
        chk("bp_delivered_once", n_hs, 1);
        #6;

        // Address range check
        in_valid = 1'b1; in_opcode = 5'd6; in_addr = 32'd256; in_rd_mem = 7'd4;
        tick();
        in_valid = 1'b0;
        chk("oor_no_req", mem_req, 0);
        chk("oor_addr_err", addr_err, 1);
        chk("oor_wb_valid", wb_valid, 1);
        chk("oor_wb_wr_en", wb_wr_en, 0);
        chk("oor_wb_result", wb_result, 0);
        in_valid = 1'b1; in_opcode = 5'd2; in_alu_result = 32'h42; in_rd_alu = 7'd1;
        tick();
        in_valid = 1'b0;
        chk("oor_sticky", addr_err, 1);
        chk("oor_next_wr_en", wb_wr_en, 1);
        in_valid = 1'b1; in_opcode = 5'd6; in_addr = 32'd255; in_rd_mem = 7'd4;
        tick();
        in_valid = 1'b0;
        chk("edge_req", mem_req, 1);
        chk("edge_addr", mem_addr, 255);
        mem_ack = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_ack = 1'b0;
        chk("edge_wb_result", wb_result, 32'h55);
        chk("edge_wb_wr_en", wb_wr_en, 1);
        tick();

        // Asynchronous reset in the middle of a load
        in_valid = 1'b1; in_opcode = 5'd6; in_addr = 32'h40;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_req_before", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_addr_err", addr_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        mem_ack = 1'b1; mem_rdata = 32'h123;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_wb", wb_valid, 0);
        chk("stray_ack_req", mem_req, 0);
        tick();
        chk("stray_ack_wb2", wb_valid, 0);

        // Randomized run against the reference model
        pend = 1'b0; exp_err = 1'b0; acc_seen = 1'b0;
        wait_cnt = $urandom_range(0, 3);
        q.delete();
        for (int c = 0; c < 1540; c++) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
            drive(c >= 1500);
        end
        chk("rnd_queue_drained", q.size(), 0);
        chk("rnd_no_pending", {31'b0, pend}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
